lz77_decomp_ctrl: RTL and testbench

LZ77 decompressor control block. It is the read/reconstruct counterpart of the sliding-window compressor control. It accepts (offset, length, literal) tokens and rebuilds the original byte stream one byte per cycle. Every emitted byte is also written into a private 64-entry history window, so later back-references can copy from it. It sits between the token unpacker and the downstream byte sink, and frames one block of BLOCK_LEN output bytes per start pulse.

---
 rtl/lz77_pkg.sv | 24 ++
 rtl/lz77_hist_win.sv | 44 ++++
 rtl/lz77_decomp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lz77_decomp_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 compressor/decompressor control blocks.
// State encodings are one-hot and common to both controllers.
package lz77_pkg;

  localparam int unsigned WinAwDefault    = 6;
  localparam int unsigned WinDepthDefault = 2 ** WinAwDefault;
  localparam int unsigned BlockLenDefault = 256;
  localparam int unsigned CntWDefault     = 9;

  localparam int unsigned TokOffW = WinAwDefault;
  localparam int unsigned TokLenW = WinAwDefault;
  localparam int unsigned TokLitW = 8;

  // StMatch is only visited by the compressor control.
  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StToken = 6'b000010,
    StCopy  = 6'b000100,
    StLit   = 6'b001000,
    StDone  = 6'b010000,
    StMatch = 6'b100000
  } lz77_state_e;

endpackage

// File: rtl/lz77_hist_win.sv
// History window: register file with async read, sync write and a per-entry
// written flag so reads of never-written history can be detected.
module lz77_hist_win
  import lz77_pkg::*;
#(
  parameter int unsigned AW = WinAwDefault
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [TokLitW-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [TokLitW-1:0] rdata_o,
  output logic               rwritten_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [TokLitW-1:0] mem_q [Depth];
  logic [Depth-1:0]   written_q;

  // Storage is intentionally not reset; written_q qualifies every read.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      written_q <= '0;
    end else if (clr_i) begin
      written_q <= '0;
    end else if (we_i) begin
      written_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign rwritten_o = written_q[raddr_i];

endmodule

// File: rtl/lz77_decomp_ctrl.sv
// LZ77 decompressor control: expands (offset, length, literal) tokens into a
// byte stream of BLOCK_LEN bytes per start, copying from a private history.
module lz77_decomp_ctrl
  import lz77_pkg::*;
#(
  parameter int unsigned WIN_AW    = WinAwDefault,
  parameter int unsigned BLOCK_LEN = BlockLenDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [WIN_AW-1:0] tok_offset,
  input  logic [WIN_AW-1:0] tok_length,
  input  logic [7:0]        tok_literal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  lz77_state_e       state_q, state_d;
  logic [WIN_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [WIN_AW-1:0] copy_left_q, copy_left_d;
  logic [WIN_AW-1:0] offset_q, offset_d;
  logic [7:0]        literal_q, literal_d;
  logic              err_q, err_d;

  logic [WIN_AW-1:0] rd_addr;
  logic [7:0]        win_rdata;
  logic              win_written;
  logic              win_clr;
  logic              xfer;
  logic              last_byte;

  // Trailing the write pointer makes overlapping copies self-replicate.
  assign rd_addr   = wr_ptr_q - offset_q;
  assign last_byte = (out_cnt_q == CNT_W'(BLOCK_LEN - 1));

  lz77_hist_win #(
    .AW(WIN_AW)
  ) u_hist_win (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr_i     (win_clr),
    .we_i      (xfer),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (out_data),
    .raddr_i   (rd_addr),
    .rdata_o   (win_rdata),
    .rwritten_o(win_written)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    out_cnt_d   = out_cnt_q;
    copy_left_d = copy_left_q;
    offset_d    = offset_q;
    literal_d   = literal_q;
    err_d       = err_q;
    tok_ready   = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    done        = 1'b0;
    win_clr     = 1'b0;
    xfer        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_clr   = 1'b1;
          wr_ptr_d  = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = StToken;
        end
      end
      StToken: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          offset_d    = tok_offset;
          copy_left_d = tok_length;
          literal_d   = tok_literal;
          if (tok_length == '0) begin
            state_d = StLit;
          end else if (tok_offset == '0) begin
            err_d   = 1'b1;
            state_d = StLit;
          end else begin
            state_d = StCopy;
          end
        end
      end
      StCopy: begin
        out_valid = 1'b1;
        out_data  = win_written ? win_rdata : 8'h00;
        if (out_ready) begin
          copy_left_d = copy_left_q - WIN_AW'(1);
          if (!win_written) begin
            err_d = 1'b1;
          end
          if (last_byte) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (copy_left_q == WIN_AW'(1)) begin
            state_d = StLit;
          end
        end
      end
      StLit: begin
        out_valid = 1'b1;
        out_data  = literal_q;
        if (out_ready) begin
          state_d = last_byte ? StDone : StToken;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    xfer = out_valid && out_ready;
    if (xfer) begin
      wr_ptr_d  = wr_ptr_q + WIN_AW'(1);
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      out_cnt_q   <= '0;
      copy_left_q <= '0;
      offset_q    <= '0;
      literal_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      out_cnt_q   <= out_cnt_d;
      copy_left_q <= copy_left_d;
      offset_q    <= offset_d;
      literal_q   <= literal_d;
      err_q       <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign err  = err_q;

endmodule

// File: tb/tb_lz77_decomp_ctrl.sv
// Directed bench for lz77_decomp_ctrl: literals, copies, back-pressure,
// error cases, block end with window wrap, and mid-block reset.
module tb_lz77_decomp_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start = 1'b0;
  logic       tok_valid = 1'b0;
  logic [5:0] tok_offset = '0;
  logic [5:0] tok_length = '0;
  logic [7:0] tok_literal = '0;
  logic       out_ready = 1'b1;
  logic       tok_ready, out_valid, busy, done, err;
  logic [7:0] out_data;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_x = -1;
  logic [7:0] got[$];
  logic [7:0] exp[$];

  lz77_decomp_ctrl dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_offset (tok_offset),
    .tok_length (tok_length),
    .tok_literal(tok_literal),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Byte and done collector, sampled mid-cycle.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_x = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_tok(input logic [5:0] off, input logic [5:0] len, input logic [7:0] lit);
    bit ok = 1'b0;
    tok_offset  = off;
    tok_length  = len;
    tok_literal = lit;
    tok_valid   = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      vecs++;
      miss++;
      $display("FAIL tok_accept_timeout got tok_ready=0 want 1");
    end
    step();
    tok_valid = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      vecs++;
      miss++;
      $display("FAIL drain_timeout got tok_ready=0 want 1");
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    obs = {tok_ready, out_valid, out_data, busy, done, err};
    for (int i = 0; i < 6; i++) begin
      vecs++;
    end
    if (obs !== 13'd0) begin
      miss++;
      $display("FAIL reset_outputs got %b want 0", obs);
    end
    if (busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    if (out_valid !== 1'b0) begin
      miss++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    if (out_data !== 8'h00) begin
      miss++;
      $display("FAIL reset_out_data got %h want 00", out_data);
    end
    if (tok_ready !== 1'b0) begin
      miss++;
      $display("FAIL reset_tok_ready got %b want 0", tok_ready);
    end
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL reset_err got %b want 0", err);
    end
  endtask

  task automatic test_start();
    got.delete();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || tok_ready !== 1'b1 || err !== 1'b0) begin
      miss++;
      $display("FAIL start_state got busy=%b rdy=%b err=%b want 1 1 0", busy, tok_ready, err);
    end
  endtask

  task automatic test_literals();
    send_tok(6'd0, 6'd0, 8'h41);
    vecs++;
    if (out_valid !== 1'b1 || out_data !== 8'h41) begin
      miss++;
      $display("FAIL lit_latency got v=%b d=%h want 1 41", out_valid, out_data);
    end
    send_tok(6'd0, 6'd0, 8'h42);
    send_tok(6'd0, 6'd0, 8'h43);
    wait_ready();
    exp = {8'h41, 8'h42, 8'h43};
    vecs++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL lit_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL lit_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    vecs++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL lit_err got %b want 0", err);
    end
  endtask

  task automatic test_copy();
    send_tok(6'd3, 6'd3, 8'h44);
    vecs++;
    if (out_valid !== 1'b1 || out_data !== 8'h41) begin
      miss++;
      $display("FAIL copy_latency got v=%b d=%h want 1 41", out_valid, out_data);
    end
    wait_ready();
    exp = {8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h44};
    vecs++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL copy_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL copy_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_overlap();
    send_tok(6'd0, 6'd0, 8'h5A);
    send_tok(6'd1, 6'd5, 8'h00);
    wait_ready();
    exp = {8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h44,
           8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00};
    vecs++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL overlap_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 7; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL overlap_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    vecs++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL overlap_err got %b want 0", err);
    end
  endtask

  task automatic test_backpressure();
    // wr_ptr=14, offset 11 reads back from index 3: 41 42 43 44.
    send_tok(6'd11, 6'd4, 8'h99);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_data !== 8'h42) begin
        miss++;
        $display("FAIL stall_hold%0d got v=%b d=%h want 1 42", i, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    wait_ready();
    exp = {exp, 8'h41, 8'h42, 8'h43, 8'h44, 8'h99};
    vecs++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL stall_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 14; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL stall_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_block_end();
    logic [7:0] v;
    bit ok = 1'b0;
    while (exp.size() < 126) begin
      v = 8'(exp.size() * 5 + 1);
      send_tok(6'd0, 6'd0, v);
      exp.push_back(v);
    end
    // wr_ptr=62: offset 63 sources straddle index 63->0 while writes wrap too.
    send_tok(6'd63, 6'd10, 8'hE1);
    for (int i = 0; i < 10; i++) begin
      exp.push_back(exp[exp.size() - 63]);
    end
    exp.push_back(8'hE1);
    while (exp.size() < 250) begin
      v = 8'(exp.size() * 5 + 1);
      send_tok(6'd0, 6'd0, v);
      exp.push_back(v);
    end
    wait_ready();
    vecs++;
    if (err !== 1'b0 || done_cnt != 0) begin
      miss++;
      $display("FAIL pre_end got err=%b done=%0d want 0 0", err, done_cnt);
    end
    // Only 6 of the 10 copy bytes fit; the rest and the literal are dropped.
    send_tok(6'd5, 6'd10, 8'hF0);
    for (int i = 0; i < 6; i++) begin
      exp.push_back(exp[exp.size() - 5]);
    end
    for (int i = 0; i < 50; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      vecs++;
      miss++;
      $display("FAIL done_timeout got done_cnt=0 want 1");
    end
    for (int i = 0; i < 4; i++) begin
      step();
    end
    vecs++;
    if (done_cnt != 1) begin
      miss++;
      $display("FAIL done_once got %0d want 1", done_cnt);
    end
    vecs++;
    if (done_cyc != last_x + 1) begin
      miss++;
      $display("FAIL done_timing got %0d want %0d", done_cyc, last_x + 1);
    end
    vecs++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL end_state got err=%b busy=%b want 1 0", err, busy);
    end
    vecs++;
    if (got.size() != 256) begin
      miss++;
      $display("FAIL end_count got %0d want 256", got.size());
    end
    for (int i = 19; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL end_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_err_unwritten();
    do_reset();
    test_start();
    send_tok(6'd0, 6'd0, 8'h11);
    send_tok(6'd0, 6'd0, 8'h22);
    send_tok(6'd0, 6'd0, 8'h33);
    send_tok(6'd0, 6'd0, 8'h44);
    wait_ready();
    vecs++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL unwr_err_before got %b want 0", err);
    end
    send_tok(6'd10, 6'd2, 8'h55);
    wait_ready();
    exp = {8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h55};
    vecs++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL unwr_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 4; i < exp.size(); i++) begin
      vecs++;
      if (got[i] !== exp[i]) begin
        miss++;
        $display("FAIL unwr_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    vecs++;
    if (err !== 1'b1) begin
      miss++;
      $display("FAIL unwr_err got %b want 1", err);
    end
  endtask

  task automatic test_err_off0();
    do_reset();
    test_start();
    send_tok(6'd0, 6'd3, 8'h7F);
    wait_ready();
    vecs++;
    if (got.size() != 1 || got[0] !== 8'h7F) begin
      miss++;
      $display("FAIL off0_bytes got n=%0d b0=%h want 1 7f", got.size(), got[0]);
    end
    vecs++;
    if (err !== 1'b1) begin
      miss++;
      $display("FAIL off0_err got %b want 1", err);
    end
  endtask

  task automatic test_reset_mid_copy();
    do_reset();
    test_start();
    send_tok(6'd0, 6'd0, 8'hAA);
    send_tok(6'd1, 6'd20, 8'hBB);
    step();
    step();
    vecs++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      miss++;
      $display("FAIL midcopy_pre got v=%b d=%h want 1 aa", out_valid, out_data);
    end
    #2;
    Rst = 1'b1;
    #1;
    vecs++;
    if ({out_valid, out_data, busy, tok_ready, done, err} !== 13'd0) begin
      miss++;
      $display("FAIL midcopy_rst got v=%b d=%h busy=%b rdy=%b done=%b err=%b want all 0",
               out_valid, out_data, busy, tok_ready, done, err);
    end
    step();
    Rst = 1'b0;
    step();
    vecs++;
    if (done_cnt != 0) begin
      miss++;
      $display("FAIL midcopy_done got %0d want 0", done_cnt);
    end
    test_start();
    send_tok(6'd0, 6'd0, 8'hCC);
    wait_ready();
    vecs++;
    if (got.size() != 1 || got[0] !== 8'hCC || err !== 1'b0) begin
      miss++;
      $display("FAIL midcopy_restart got n=%0d b0=%h err=%b want 1 cc 0",
               got.size(), got[0], err);
    end
  endtask

  initial begin
    #12;
    test_reset();
    step();
    Rst = 1'b0;
    step();
    test_start();
    test_literals();
    test_copy();
    test_overlap();
    test_backpressure();
    test_block_end();
    test_err_unwritten();
    test_err_off0();
    test_reset_mid_copy();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
